// File: rtl/data_mem_responder.sv
// data_mem_responder: responder for the core's data memory port.
// Stores are decoded into word entries and queued in a small write buffer that
// drains into a single-port word array on cycles with no load. Loads have one
// cycle of latency and see pending buffered stores through byte-lane forwarding.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_rd_en,
  input  logic [31:0] data_rd_addr,
  output logic [31:0] data_rd_data,
  input  logic [1:0]  data_wr,
  input  logic [31:0] data_wr_addr,
  input  logic [31:0] data_wr_data,
  output logic        wbuf_full,
  output logic        wbuf_empty,
  output logic        err_misalign,
  output logic        err_range,
  output logic        err_overflow
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);

  // Word array and write-buffer storage carry no reset.
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   mem_rdata;
  logic [AW-1:0] buf_waddr [WBUF_DEPTH];
  logic [3:0]    buf_be    [WBUF_DEPTH];
  logic [31:0]   buf_wdata [WBUF_DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          misalign_q, misalign_d, range_q, range_d, overflow_q, overflow_d;
  logic          rd_ok_q, rd_ok_d;
  logic [3:0]    fwd_mask_q, fwd_mask_d;
  logic [31:0]   fwd_data_q, fwd_data_d;

  logic [29:0]   st_waddr, rd_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic          st_req, st_misalign, st_oor, st_valid;
  logic          rd_oor, drain, push;
  logic [PW-1:0] slot;

  assign st_waddr = data_wr_addr[31:2];
  assign rd_idx   = data_rd_addr[31:2];
  assign st_req   = (data_wr != 2'b00);
  assign st_oor   = (st_waddr >= 30'(DEPTH_WORDS));
  assign rd_oor   = (rd_idx >= 30'(DEPTH_WORDS));
  assign st_valid = st_req && !st_misalign && !st_oor;
  // The array port is shared, so a load in the same cycle holds off the drain.
  assign drain    = !data_rd_en && (count_q != '0);
  // A full buffer still accepts a store when the head leaves in the same cycle.
  assign push     = st_valid && ((count_q != FULL_CNT) || drain);

  // Store decode: place the right-justified data on its byte lanes.
  always_comb begin
    st_be       = 4'b0000;
    st_wdata    = 32'h0;
    st_misalign = 1'b0;
    case (data_wr)
      2'b01: begin
        st_be    = 4'b0001 << data_wr_addr[1:0];
        st_wdata = {4{data_wr_data[7:0]}};
      end
      2'b10: begin
        st_misalign = data_wr_addr[0];
        st_be       = data_wr_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata    = {2{data_wr_data[15:0]}};
      end
      2'b11: begin
        st_misalign = |data_wr_addr[1:0];
        st_be       = 4'b1111;
        st_wdata    = data_wr_data;
      end
      default: ;
    endcase
  end

  // Load forwarding: oldest-to-newest walk so the newest matching entry wins,
  // then the store accepted this cycle overrides everything.
  always_comb begin
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    rd_ok_d    = rd_ok_q;
    slot       = head_q;
    if (data_rd_en) begin
      fwd_mask_d = 4'b0000;
      fwd_data_d = 32'h0;
      rd_ok_d    = !rd_oor;
      for (int k = 0; k < WBUF_DEPTH; k++) begin
        slot = head_q + PW'(k);
        if ((CW'(k) < count_q) && (buf_waddr[slot] == rd_idx[AW-1:0])) begin
          for (int b = 0; b < 4; b++) begin
            if (buf_be[slot][b]) begin
              fwd_mask_d[b]        = 1'b1;
              fwd_data_d[8*b +: 8] = buf_wdata[slot][8*b +: 8];
            end
          end
        end
      end
      if (push && (st_waddr[AW-1:0] == rd_idx[AW-1:0])) begin
        for (int b = 0; b < 4; b++) begin
          if (st_be[b]) begin
            fwd_mask_d[b]        = 1'b1;
            fwd_data_d[8*b +: 8] = st_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Buffer bookkeeping and sticky error flags.
  always_comb begin
    head_d     = head_q + PW'(drain);
    tail_d     = tail_q + PW'(push);
    count_d    = count_q + CW'(push) - CW'(drain);
    full_d     = (count_d == FULL_CNT);
    empty_d    = (count_d == '0);
    misalign_d = misalign_q | (st_req && st_misalign);
    range_d    = range_q | (st_req && !st_misalign && st_oor);
    overflow_d = overflow_q | (st_valid && !push);
  end

  // Control state, error flags and load-forwarding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      overflow_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      fwd_mask_q <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      misalign_q <= misalign_d;
      range_q    <= range_d;
      overflow_q <= overflow_d;
      rd_ok_q    <= rd_ok_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Buffer entry write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_waddr[tail_q] <= st_waddr[AW-1:0];
      buf_be[tail_q]    <= st_be;
      buf_wdata[tail_q] <= st_wdata;
    end
  end

  // Single-port array: byte-masked drain write or word read, never both.
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_be[head_q][b]) mem[buf_waddr[head_q]][8*b +: 8] <= buf_wdata[head_q][8*b +: 8];
      end
    end
    if (data_rd_en && !rd_oor) mem_rdata <= mem[rd_idx[AW-1:0]];
  end

  // Merge forwarded lanes over array data; out-of-range or post-reset reads give 0.
  always_comb begin
    data_rd_data = 32'h0;
    for (int b = 0; b < 4; b++) begin
      data_rd_data[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : mem_rdata[8*b +: 8];
    end
    if (!rd_ok_q) data_rd_data = 32'h0;
  end

  assign wbuf_full    = full_q;
  assign wbuf_empty   = empty_q;
  assign err_misalign = misalign_q;
  assign err_range    = range_q;
  assign err_overflow = overflow_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a vector table for single-cycle behaviour plus
// hand sequences for buffer overflow and reset during drain. Load results go
// through a scoreboard queue filled when the load is issued.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_rd_en;
  logic [31:0] data_rd_addr;
  logic [31:0] data_rd_data;
  logic [1:0]  data_wr;
  logic [31:0] data_wr_addr;
  logic [31:0] data_wr_data;
  logic        wbuf_full, wbuf_empty, err_misalign, err_range, err_overflow;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] sb_q[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .WBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
    .data_wr(data_wr), .data_wr_addr(data_wr_addr), .data_wr_data(data_wr_data),
    .wbuf_full(wbuf_full), .wbuf_empty(wbuf_empty),
    .err_misalign(err_misalign), .err_range(err_range), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] raddr;
    logic [1:0]  wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        hold;
    logic        exp_empty;
    logic        exp_full;
    logic [2:0]  exp_err;   // {overflow, range, misalign}
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected load result, sample #1 after the edge.
  task automatic step(input logic rd, input logic [31:0] raddr, input logic [1:0] wr,
                      input logic [31:0] waddr, input logic [31:0] wdata,
                      input logic chk_rd, input logic [31:0] exp_rd);
    data_rd_en   = rd;
    data_rd_addr = raddr;
    data_wr      = wr;
    data_wr_addr = waddr;
    data_wr_data = wdata;
    if (rd && chk_rd) sb_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    if (rd && chk_rd) begin
      if (sb_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL scoreboard: queue empty");
      end else begin
        chk("load", data_rd_data, sb_q.pop_front());
      end
    end
    data_rd_en = 1'b0;
    data_wr    = 2'b00;
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic f, input logic [2:0] er);
    chk({tag, " empty"}, {31'b0, wbuf_empty}, {31'b0, e});
    chk({tag, " full"},  {31'b0, wbuf_full},  {31'b0, f});
    chk({tag, " err"},   {29'b0, err_overflow, err_range, err_misalign}, {29'b0, er});
  endtask

  function automatic vec_t mk(input logic rd, input logic [31:0] raddr, input logic [1:0] wr,
                              input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic hold,
                              input logic e, input logic [2:0] er);
    vec_t v;
    v.rd = rd; v.raddr = raddr; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.hold = hold; v.exp_empty = e; v.exp_full = 1'b0; v.exp_err = er;
    return v;
  endfunction

  logic [31:0] w5 [5];

  initial begin
    //           rd  raddr     wr     waddr     wdata         exp_rd        hold e  err
    tbl[0]  = mk(1, 32'h10,   2'b11, 32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 3'b000);
    tbl[1]  = mk(0, 32'h0,    2'b00, 32'h0,    32'h0,        32'hDEADBEEF, 1, 1, 3'b000);
    tbl[2]  = mk(0, 32'h0,    2'b11, 32'h20,   32'h11223344, 32'h0,        0, 0, 3'b000);
    tbl[3]  = mk(0, 32'h0,    2'b00, 32'h0,    32'h0,        32'h0,        0, 1, 3'b000);
    tbl[4]  = mk(1, 32'h20,   2'b01, 32'h23,   32'h000000AA, 32'hAA223344, 0, 0, 3'b000);
    tbl[5]  = mk(1, 32'h20,   2'b00, 32'h0,    32'h0,        32'hAA223344, 0, 0, 3'b000);
    tbl[6]  = mk(0, 32'h0,    2'b00, 32'h0,    32'h0,        32'h0,        0, 1, 3'b000);
    tbl[7]  = mk(1, 32'h20,   2'b00, 32'h0,    32'h0,        32'hAA223344, 0, 1, 3'b000);
    tbl[8]  = mk(0, 32'h0,    2'b10, 32'h21,   32'h00005555, 32'h0,        0, 1, 3'b001);
    tbl[9]  = mk(1, 32'h20,   2'b00, 32'h0,    32'h0,        32'hAA223344, 0, 1, 3'b001);
    tbl[10] = mk(0, 32'h0,    2'b01, 32'h1000, 32'h00000099, 32'h0,        0, 1, 3'b011);
    tbl[11] = mk(1, 32'h1000, 2'b00, 32'h0,    32'h0,        32'h0,        0, 1, 3'b011);
    tbl[12] = mk(1, 32'h10,   2'b10, 32'h12,   32'h00001234, 32'h1234BEEF, 0, 0, 3'b011);
    tbl[13] = mk(0, 32'h0,    2'b00, 32'h0,    32'h0,        32'h0,        0, 1, 3'b011);
    tbl[14] = mk(1, 32'h10,   2'b00, 32'h0,    32'h0,        32'h1234BEEF, 0, 1, 3'b011);
    tbl[15] = mk(0, 32'h0,    2'b01, 32'h11,   32'h00000077, 32'h0,        0, 0, 3'b011);
    tbl[16] = mk(1, 32'h10,   2'b00, 32'h0,    32'h0,        32'h123477EF, 0, 0, 3'b011);
    tbl[17] = mk(0, 32'h0,    2'b00, 32'h0,    32'h0,        32'h0,        0, 1, 3'b011);
    tbl[18] = mk(1, 32'h10,   2'b00, 32'h0,    32'h0,        32'h123477EF, 0, 1, 3'b011);
    tbl[19] = mk(0, 32'h0,    2'b00, 32'h0,    32'h0,        32'h123477EF, 1, 1, 3'b011);

    // Reset state
    rst = 1'b1; data_rd_en = 1'b0; data_rd_addr = '0;
    data_wr = 2'b00; data_wr_addr = '0; data_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", data_rd_data, 32'h0);
    chk_flags("reset", 1'b1, 1'b0, 3'b000);
    rst = 1'b0;

    // Vector table: forwarding, drains, misaligned/out-of-range drops
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rd, tbl[i].raddr, tbl[i].wr, tbl[i].waddr, tbl[i].wdata, 1'b1, tbl[i].exp_rd);
      if (tbl[i].hold && !tbl[i].rd) chk($sformatf("hold row%0d", i), data_rd_data, tbl[i].exp_rd);
      chk_flags($sformatf("row%0d", i), tbl[i].exp_empty, tbl[i].exp_full, tbl[i].exp_err);
    end

    // Overflow: loads held on an out-of-range address so no drain occurs
    for (int i = 0; i < 5; i++) begin
      w5[i] = 32'hA0000000 + 32'(i * 17);
      step(1'b1, 32'h1000, 2'b11, 32'h40 + 32'(4 * i), w5[i], 1'b1, 32'h0);
      chk_flags($sformatf("ovf push%0d", i), 1'b0, (i >= 3), {(i == 4), 2'b11});
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      chk_flags($sformatf("ovf drain%0d", j), (j == 3), 1'b0, 3'b111);
    end
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h40 + 32'(4 * i), 2'b00, 32'h0, 32'h0, 1'b1, w5[i]);
    step(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("ovf hold", data_rd_data, w5[3]);

    // Reset during drain: seed old values, queue three new ones, drain one, reset
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 2'b11, 32'h100 + 32'(4 * i), 32'h0BAD0000 + 32'(i), 1'b0, 32'h0);
    repeat (3) step(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("seed empty", {31'b0, wbuf_empty}, 32'h1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h1000, 2'b11, 32'h100 + 32'(4 * i), 32'h600D0000 + 32'(i), 1'b1, 32'h0);
    step(1'b1, 32'h108, 2'b00, 32'h0, 32'h0, 1'b1, 32'h600D0002);
    step(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("pre-rst empty", {31'b0, wbuf_empty}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid rst rd_data", data_rd_data, 32'h0);
    chk_flags("mid rst", 1'b1, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 32'h100, 2'b00, 32'h0, 32'h0, 1'b1, 32'h600D0000);
    step(1'b1, 32'h104, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0BAD0001);
    step(1'b1, 32'h108, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0BAD0002);
    chk_flags("post rst", 1'b1, 1'b0, 3'b000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
